// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Imported by the channel and top-level modules.
package clk_div_pkg;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_DIV_SCAN  = 25000;
   localparam int DEF_DIV_BLINK = 25_000_000;

   // A single channel still needs a 1-bit select port.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: phase counter, divisor register, tick strobe and
// square-wave output, with clear > load > count priority.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int          WIDTH   = DEF_WIDTH,
   parameter int unsigned DEF_DIV = DEF_DIV_SCAN
) (
   input  logic             clk0,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_div,
   output logic             tick,
   output logic             clk_out,
   output logic [WIDTH-1:0] div
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic             clk_q, clk_d;
   logic             wrap;

   assign wrap = (cnt_q == div_q - WIDTH'(1));

   always_comb begin
      div_d  = div_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      clk_d  = clk_q;
      if (load) begin
         div_d = load_div;
      end
      if (clr) begin
         cnt_d = '0;
         clk_d = 1'b0;
      end else if (load) begin
         cnt_d = '0;
      end else if (en && (div_q != '0)) begin
         if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            clk_d  = ~clk_q;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         div_q  <= WIDTH'(DEF_DIV);
         tick_q <= 1'b0;
         clk_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         tick_q <= tick_d;
         clk_q  <= clk_d;
      end
   end

   assign tick    = tick_q;
   assign clk_out = clk_q;
   assign div     = div_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel tick strobes and
// 50%-duty square waves with runtime divisor writes and global re-phase.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter  int          NCH     = 2,
   parameter  int          WIDTH   = DEF_WIDTH,
   parameter  int unsigned DEF_DIV = DEF_DIV_SCAN,
   localparam int          CH_W    = clog2_min1(NCH)
) (
   input  logic                 clk0,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       en,
   input  logic                 sync_clr,
   input  logic                 wr_en,
   input  logic [CH_W-1:0]      wr_ch,
   input  logic [WIDTH-1:0]     wr_div,
   output logic [NCH-1:0]       tick,
   output logic [NCH-1:0]       clk_out,
   output logic [NCH*WIDTH-1:0] div_q
);

   logic           wr_hit;
   logic [NCH-1:0] load;

   // Out-of-range channel indices are dropped here, before decode.
   assign wr_hit = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(NCH));

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign load[i] = wr_hit && (wr_ch == CH_W'(i));

      clk_div_chan #(
         .WIDTH   (WIDTH),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk0     (clk0),
         .rst_n    (rst_n),
         .en       (en[i]),
         .clr      (sync_clr),
         .load     (load[i]),
         .load_div (wr_div),
         .tick     (tick[i]),
         .clk_out  (clk_out[i]),
         .div      (div_q[i*WIDTH +: WIDTH])
      );
   end

endmodule
